regfile_scoreboard: RTL and testbench

Integer register file plus pending-write scoreboard feeding the decode/issue stage. It accepts the single register-file write produced by the writeback stage (enable, address, data) and serves two combinational read ports with same-cycle write-through bypass. A per-register busy bit tracks outstanding long-latency producers (loads, divides) so that issue stalls on read-after-write hazards until the matching writeback lands.

---
 rtl/regfile_scoreboard.sv | 88 ++++++++
 tb/tb_regfile_scoreboard.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-through bypass, plus a per-register busy
// scoreboard that stalls issue on RAW hazards against long-latency producers.
module regfile_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            issue_valid_i,
  input  logic [4:0]      issue_rd_i,
  input  logic            issue_long_i,
  input  logic            issue_rs1_used_i,
  input  logic            issue_rs2_used_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [NREG-1:0] busy_o
);

  logic [XLEN-1:0] regs [1:NREG-1];
  logic [NREG-1:0] busy_q, busy_d;
  logic            hz1, hz2, issue_accept;

  // NOTE: this array is reset on purpose, because x1..x31 must read zero after
  // reset; that rules out a plain RAM macro for this block.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 1; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en_i && wb_addr_i != '0) begin
      regs[wb_addr_i] <= wb_data_i;
    end
  end

  // x0 reads zero; a writeback landing this cycle is forwarded ahead of the array.
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
    logic [XLEN-1:0] data;
    data = '0;
    if (addr != '0) begin
      if (wb_en_i && wb_addr_i == addr) data = wb_data_i;
      else                              data = regs[addr];
    end
    return data;
  endfunction

  // NOTE: combinational logic uses blocking assignments and gives every output
  // a value on every path, so no latch is inferred.
  always_comb begin
    rs1_data_o = read_port(rs1_addr_i);
    rs2_data_o = read_port(rs2_addr_i);
  end

  always_comb begin
    hz1 = issue_rs1_used_i && rs1_addr_i != '0 && busy_q[rs1_addr_i]
          && !(wb_en_i && wb_addr_i == rs1_addr_i);
    hz2 = issue_rs2_used_i && rs2_addr_i != '0 && busy_q[rs2_addr_i]
          && !(wb_en_i && wb_addr_i == rs2_addr_i);
    stall_o      = issue_valid_i && (hz1 || hz2);
    issue_accept = issue_valid_i && !stall_o && !flush_i;
  end

  // Clear on writeback first, then set on issue, so a new producer to the
  // same register stays outstanding.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (wb_en_i) busy_d[wb_addr_i] = 1'b0;
      if (issue_accept && issue_long_i && issue_rd_i != '0) busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: state registers are updated with non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: stimulus pushes hand-computed
// expectations into a queue; a monitor pops and compares them on the falling edge.
module tb_regfile_scoreboard;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef enum int { K_RS1, K_RS2, K_STALL, K_BUSY } kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [31:0] val;
  } exp_t;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            wb_en_i;
  logic [4:0]      wb_addr_i;
  logic [XLEN-1:0] wb_data_i;
  logic [4:0]      rs1_addr_i, rs2_addr_i;
  logic [XLEN-1:0] rs1_data_o, rs2_data_o;
  logic            issue_valid_i, issue_long_i, issue_rs1_used_i, issue_rs2_used_i;
  logic [4:0]      issue_rd_i;
  logic            flush_i;
  logic            stall_o;
  logic [NREG-1:0] busy_o;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .wb_en_i          (wb_en_i),
    .wb_addr_i        (wb_addr_i),
    .wb_data_i        (wb_data_i),
    .rs1_addr_i       (rs1_addr_i),
    .rs2_addr_i       (rs2_addr_i),
    .rs1_data_o       (rs1_data_o),
    .rs2_data_o       (rs2_data_o),
    .issue_valid_i    (issue_valid_i),
    .issue_rd_i       (issue_rd_i),
    .issue_long_i     (issue_long_i),
    .issue_rs1_used_i (issue_rs1_used_i),
    .issue_rs2_used_i (issue_rs2_used_i),
    .flush_i          (flush_i),
    .stall_o          (stall_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic push(input string name, input kind_e kind, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Monitor: the design is combinational on its outputs, so every falling
  // edge is a point where the DUT presents a response worth checking.
  initial begin
    forever begin
      @(negedge clk_i);
      while (exp_q.size() != 0) begin
        exp_t e;
        logic [31:0] act;
        e = exp_q.pop_front();
        case (e.kind)
          K_RS1:   act = rs1_data_o;
          K_RS2:   act = rs2_data_o;
          K_STALL: act = {31'b0, stall_o};
          default: act = busy_o;
        endcase
        n_vec++;
        if (act !== e.val) begin
          n_miss++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic idle();
    wb_en_i = 0; wb_addr_i = 0; wb_data_i = 0;
    rs1_addr_i = 0; rs2_addr_i = 0;
    issue_valid_i = 0; issue_rd_i = 0; issue_long_i = 0;
    issue_rs1_used_i = 0; issue_rs2_used_i = 0;
    flush_i = 0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en_i = 1; wb_addr_i = a; wb_data_i = d;
  endtask

  task automatic issue(input logic [4:0] rd, input logic lng,
                       input logic u1, input logic [4:0] a1,
                       input logic u2, input logic [4:0] a2);
    issue_valid_i = 1; issue_rd_i = rd; issue_long_i = lng;
    issue_rs1_used_i = u1; rs1_addr_i = a1;
    issue_rs2_used_i = u2; rs2_addr_i = a2;
  endtask

  initial begin
    idle();
    rst_ni = 0;
    step();
    // Reset state
    rs1_addr_i = 5;
    push("reset_busy", K_BUSY, 32'h0);
    push("reset_rs1_x5", K_RS1, 32'h0);
    push("reset_stall", K_STALL, 32'h0);
    step();
    rst_ni = 1;

    // Write x5, read it back through the array on the next cycle
    idle(); wb(5, 32'hDEADBEEF); rs1_addr_i = 6;
    push("x6_unwritten", K_RS1, 32'h0);
    step();
    idle(); rs1_addr_i = 5;
    push("x5_readback", K_RS1, 32'hDEADBEEF);
    step();

    // x0: write discarded, long issue to rd=0 sets nothing
    idle(); wb(0, 32'hFFFFFFFF); issue(0, 1, 0, 0, 0, 0);
    push("x0_bypass_blocked", K_RS2, 32'h0);
    step();
    idle(); rs2_addr_i = 0;
    push("x0_read", K_RS2, 32'h0);
    push("x0_busy", K_BUSY, 32'h0);
    step();

    // Bypass
    idle(); wb(7, 32'h11);
    step();
    idle(); wb(7, 32'h22); rs1_addr_i = 7;
    push("bypass_rs1_x7", K_RS1, 32'h22);
    step();
    idle(); rs1_addr_i = 7; rs2_addr_i = 7;
    push("x7_stored_rs1", K_RS1, 32'h22);
    push("x7_stored_rs2", K_RS2, 32'h22);
    step();

    // Load-use stall on x3
    idle(); issue(3, 1, 0, 0, 0, 0);
    step();
    idle(); issue(1, 0, 1, 3, 0, 0);
    push("ld_busy3", K_BUSY, 32'h8);
    push("ld_stall_c1", K_STALL, 32'h1);
    step();
    push("ld_stall_c2", K_STALL, 32'h1);
    step();
    push("ld_stall_c3", K_STALL, 32'h1);
    step();
    wb(3, 32'h55);
    push("ld_wb_nostall", K_STALL, 32'h0);
    push("ld_wb_bypass", K_RS1, 32'h55);
    step();
    idle(); rs1_addr_i = 3;
    push("ld_busy_cleared", K_BUSY, 32'h0);
    push("ld_x3_stored", K_RS1, 32'h55);
    step();

    // Set/clear collision on x4
    idle(); issue(4, 1, 0, 0, 0, 0);
    step();
    idle(); wb(4, 32'h44); issue(4, 1, 0, 0, 0, 0);
    push("col_busy_before", K_BUSY, 32'h10);
    push("col_no_stall", K_STALL, 32'h0);
    step();
    idle(); rs1_addr_i = 4;
    push("col_busy_after", K_BUSY, 32'h10);
    push("col_x4_written", K_RS1, 32'h44);
    step();

    // Flush with busy = {x3, x9}
    idle(); wb(4, 32'h45); issue(3, 1, 0, 0, 0, 0);
    step();
    idle(); issue(9, 1, 0, 0, 0, 0);
    step();
    idle(); flush_i = 1; issue(10, 1, 0, 0, 0, 0); wb(9, 32'h77);
    push("fl_busy_before", K_BUSY, 32'h208);
    step();
    idle(); rs1_addr_i = 9;
    push("fl_busy_cleared", K_BUSY, 32'h0);
    push("fl_x9_written", K_RS1, 32'h77);
    step();

    // Reset mid-stall on an rs2 hazard
    idle(); issue(12, 1, 0, 0, 0, 0);
    step();
    idle(); issue(13, 0, 0, 5, 1, 12); rst_ni = 0;
    push("rst_pre_stall", K_STALL, 32'h1);
    push("rst_pre_x5", K_RS1, 32'hDEADBEEF);
    step();
    rst_ni = 1;
    push("rst_post_stall", K_STALL, 32'h0);
    push("rst_post_x5", K_RS1, 32'h0);
    push("rst_post_x12", K_RS2, 32'h0);
    push("rst_post_busy", K_BUSY, 32'h0);
    step();
    idle();

    @(negedge clk_i);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
